delay_line_ch: RTL and testbench

- Programmable delay stage directly downstream of a channel pulse generator.
- Consumes the generator's end-of-pulse level flag (launch_DL).
- After a programmable number of clk_Pulse cycles, asserts a held start level that drives the next channel's pulse generator (its PL_start).
- Chained between channels to build the optical synchronising pulse sequence.

---
 rtl/pulse_pkg.sv | 16 +
 rtl/rise_edge_det.sv | 33 +++
 rtl/delay_line_ch.sv | 137 +++++++++++++
 tb/tb_delay_line_ch.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared definitions for the channel pulse chain stages.
//   CNT_W_DEF  : default width of delay values and delay counters
//   dl_state_t : delay-line FSM states. StHoldoff keeps its encoding even in builds
//                without the hold limit, so state encodings match across builds.
package pulse_pkg;

    localparam int unsigned CNT_W_DEF = 36;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCount   = 2'd1,
        StFire    = 2'd2,
        StHoldoff = 2'd3
    } dl_state_t;

endpackage

// File: rtl/rise_edge_det.sv
// Registered rising-edge detector with synchronous active-high reset.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   d    : level input
//   rise : high for one cycle when d is high now and was low at the previous edge
// The detector arms only after it has sampled d low at least once since reset.
// A level that is already high when reset is released is therefore not a rising edge.
module rise_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;
    logic armed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q     <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            d_q <= d;
            if (!d) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign rise = d & ~d_q & armed_q;

endmodule

// File: rtl/delay_line_ch.sv
// Programmable delay stage between two channel pulse generators.
// A rising edge on DL_launch starts a count of `delay` clk_Pulse cycles.
// PL_start_next then goes high and stays high while DL_launch stays high.
// A low DL_launch at any point returns the stage to idle.
// Ports:
//   clk_Pulse     : clock, rising edge
//   rst           : synchronous active-high reset
//   DL_launch     : end-of-pulse level from the upstream stage
//   delay         : delay in cycles, sampled at launch
//   DL_enable     : gates new launches only
//   PL_start_next : held start level for the downstream generator
//   DL_busy       : high while counting or firing
//   DL_fault      : sticky hold-timeout flag (0 unless DL_MAX_HOLD_EN)
// Build option: define DL_MAX_HOLD_EN to enable the hold limit.
// With it, PL_start_next drops after MAX_HOLD cycles high, DL_fault is set,
// and the FSM waits in StHoldoff until DL_launch goes low.
module delay_line_ch
    import pulse_pkg::*;
#(
    parameter int unsigned        CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0]   MAX_HOLD = CNT_W'(1000000)
) (
    input  logic             clk_Pulse,
    input  logic             rst,
    input  logic             DL_launch,
    input  logic [CNT_W-1:0] delay,
    input  logic             DL_enable,
    output logic             PL_start_next,
    output logic             DL_busy,
    output logic             DL_fault
);

    dl_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] dly_q, dly_d;
    logic             launch;

    rise_edge_det u_edge (
        .clk  (clk_Pulse),
        .rst  (rst),
        .d    (DL_launch),
        .rise (launch)
    );

`ifdef DL_MAX_HOLD_EN
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             fault_q, fault_d;
`else
    logic unused_max_hold;
    assign unused_max_hold = ^MAX_HOLD;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dly_d   = dly_q;
`ifdef DL_MAX_HOLD_EN
        hold_d  = hold_q;
        fault_d = fault_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (launch && DL_enable) begin
                    dly_d   = delay;
                    cnt_d   = '0;
                    state_d = StCount;
                end
            end
            StCount: begin
                if (!DL_launch) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (cnt_q == dly_q) begin
                    // The equality compare stops counting at the terminal value.
                    // An all-ones delay therefore fires without the counter wrapping.
                    state_d = StFire;
`ifdef DL_MAX_HOLD_EN
                    hold_d  = CNT_W'(1); // the first high cycle starts at this edge
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StFire: begin
                if (!DL_launch) begin
                    state_d = StIdle;
`ifdef DL_MAX_HOLD_EN
                end else if (hold_q == MAX_HOLD) begin
                    state_d = StHoldoff;
                    fault_d = 1'b1;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
`endif
                end
            end
            StHoldoff: begin
`ifdef DL_MAX_HOLD_EN
                if (!DL_launch) begin
                    state_d = StIdle;
                end
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_Pulse) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dly_q   <= '0;
`ifdef DL_MAX_HOLD_EN
            hold_q  <= '0;
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dly_q   <= dly_d;
`ifdef DL_MAX_HOLD_EN
            hold_q  <= hold_d;
            fault_q <= fault_d;
`endif
        end
    end

    assign PL_start_next = (state_q == StFire);
    assign DL_busy       = (state_q == StCount) || (state_q == StFire);
`ifdef DL_MAX_HOLD_EN
    assign DL_fault      = fault_q;
`else
    assign DL_fault      = 1'b0;
`endif

endmodule

// File: tb/tb_delay_line_ch.sv
// Scoreboard bench for delay_line_ch.
// The stimulus pushes the expected PL_start_next transitions, each as a kind and an edge index.
// The monitor pops one entry on every observed transition of PL_start_next.
// A 4-bit instance checks the all-ones delay boundary in reasonable time.
module tb_delay_line_ch;

    localparam int unsigned W = 36;

    logic         clk = 1'b0;
    logic         rst;
    logic         launch;
    logic         enable;
    logic [W-1:0] delay;
    logic         pl, busy, fault;

    logic         s_launch;
    logic [3:0]   s_delay;
    logic         s_pl, s_busy, s_fault;

    int unsigned      tests = 0;
    int unsigned      fails = 0;
    longint unsigned  cyc = 0;

    typedef struct {
        bit              rise;
        longint unsigned edge_idx;
    } ev_t;
    ev_t exp_q[$];

    delay_line_ch #(.CNT_W(W), .MAX_HOLD(36'd8)) u_dut (
        .clk_Pulse     (clk),
        .rst           (rst),
        .DL_launch     (launch),
        .delay         (delay),
        .DL_enable     (enable),
        .PL_start_next (pl),
        .DL_busy       (busy),
        .DL_fault      (fault)
    );

    delay_line_ch #(.CNT_W(4), .MAX_HOLD(4'd8)) u_small (
        .clk_Pulse     (clk),
        .rst           (rst),
        .DL_launch     (s_launch),
        .delay         (s_delay),
        .DL_enable     (enable),
        .PL_start_next (s_pl),
        .DL_busy       (s_busy),
        .DL_fault      (s_fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Return at the negedge just before edge e; inputs set now are sampled at e.
    task automatic at_edge(input longint unsigned e);
        while (cyc + 1 < e) @(negedge clk);
    endtask

    // Return at the negedge following edge e.
    task automatic after_edge(input longint unsigned e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic start(input logic [W-1:0] d, output longint unsigned t0);
        delay  = d;
        launch = 1'b1;
        t0     = cyc + 1;
    endtask

    task automatic expect_ev(input bit rise, input longint unsigned e);
        ev_t ev;
        ev.rise     = rise;
        ev.edge_idx = e;
        exp_q.push_back(ev);
    endtask

    // Monitor: every PL_start_next transition must match the next scoreboard entry.
    logic pl_prev = 1'b0;
    always @(negedge clk) begin
        ev_t ev;
        if (pl !== pl_prev) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_edge: PL_start_next became %b at edge %0d, none expected",
                         pl, cyc);
            end else begin
                ev = exp_q.pop_front();
                check("edge_kind", longint'(pl), longint'(ev.rise));
                check("edge_cycle", cyc, ev.edge_idx);
            end
        end
        pl_prev = pl;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete, edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        longint unsigned t0;
        rst      = 1'b1;
        launch   = 1'b0;
        enable   = 1'b1;
        delay    = '0;
        s_launch = 1'b0;
        s_delay  = '0;

        // 1: reset for three edges, then release with launch low
        repeat (3) @(negedge clk);
        check("rst_pl", longint'(pl), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_fault", longint'(fault), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", longint'(busy), 0);

        // 2: delay 5, rise at T0+6, fall on the edge that samples launch low
        start(36'd5, t0);
        expect_ev(1'b1, t0 + 6);
        after_edge(t0 + 1);
        check("busy_count", longint'(busy), 1);
        at_edge(t0 + 9);
        launch = 1'b0;
        expect_ev(1'b0, t0 + 9);
        after_edge(t0 + 9);
        check("busy_after_drop", longint'(busy), 0);

        // 3a: delay 0 fires on the edge after launch
        start(36'd0, t0);
        expect_ev(1'b1, t0 + 1);
        at_edge(t0 + 4);
        launch = 1'b0;
        expect_ev(1'b0, t0 + 4);
        after_edge(t0 + 4);

        // 3b: all-ones delay on a 4-bit instance fires at T0+16 without wrapping
        s_delay  = 4'hF;
        s_launch = 1'b1;
        t0       = cyc + 1;
        after_edge(t0 + 15);
        check("max_not_yet", longint'(s_pl), 0);
        after_edge(t0 + 16);
        check("max_fire", longint'(s_pl), 1);
        check("max_busy", longint'(s_busy), 1);
        at_edge(t0 + 18);
        s_launch = 1'b0;
        after_edge(t0 + 18);
        check("max_drop_pl", longint'(s_pl), 0);
        check("max_drop_busy", longint'(s_busy), 0);

        // 3c: full-width all-ones delay just counts; abort it
        start('1, t0);
        after_edge(t0 + 60);
        check("wide_busy", longint'(busy), 1);
        launch = 1'b0;
        @(negedge clk);
        check("wide_abort_busy", longint'(busy), 0);

        // 4a: abort mid-count, no output
        start(36'd100, t0);
        at_edge(t0 + 40);
        launch = 1'b0;
        after_edge(t0 + 40);
        check("abort_busy", longint'(busy), 0);
        @(negedge clk);

        // 4b: delay changed after launch has no effect
        start(36'd100, t0);
        at_edge(t0 + 10);
        delay = 36'd3;
        expect_ev(1'b1, t0 + 101);
        after_edge(t0 + 20);
        check("late_delay_busy", longint'(busy), 1);
        at_edge(t0 + 104);
        launch = 1'b0;
        expect_ev(1'b0, t0 + 104);
        after_edge(t0 + 104);

        // 5a: disabled launch is dropped, not queued
        enable = 1'b0;
        start(36'd2, t0);
        after_edge(t0 + 1);
        check("disabled_busy", longint'(busy), 0);
        enable = 1'b1;
        after_edge(t0 + 8);
        check("no_queued_launch", longint'(busy), 0);
        launch = 1'b0;
        @(negedge clk);

        // 5b: reset in FIRE clears output; a held launch after reset is not a launch
        start(36'd1, t0);
        expect_ev(1'b1, t0 + 2);
        at_edge(t0 + 4);
        rst = 1'b1;
        expect_ev(1'b0, t0 + 4);
        after_edge(t0 + 4);
        rst = 1'b0;
        check("rst_fire_busy", longint'(busy), 0);
        after_edge(t0 + 10);
        check("no_launch_after_rst", longint'(busy), 0);
        launch = 1'b0;
        @(negedge clk);

        // 6: hold limit (MAX_HOLD = 8)
        start(36'd2, t0);
        expect_ev(1'b1, t0 + 3);
`ifdef DL_MAX_HOLD_EN
        expect_ev(1'b0, t0 + 11);
        after_edge(t0 + 11);
        check("hold_fault", longint'(fault), 1);
        check("hold_busy", longint'(busy), 0);
        at_edge(t0 + 14);
        launch = 1'b0;
        after_edge(t0 + 14);
        check("fault_sticky", longint'(fault), 1);
        check("holdoff_exit_busy", longint'(busy), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("fault_cleared", longint'(fault), 0);
`else
        after_edge(t0 + 15);
        check("long_hold_pl", longint'(pl), 1);
        check("long_hold_fault", longint'(fault), 0);
        check("long_hold_busy", longint'(busy), 1);
        at_edge(t0 + 16);
        launch = 1'b0;
        expect_ev(1'b0, t0 + 16);
        after_edge(t0 + 16);
        check("long_hold_drop_busy", longint'(busy), 0);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", longint'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
